// File: rtl/full_adder_unit_if.sv
// Operand/result bundle for full_adder_unit.
// The ovf signal is present only when FULL_ADDER_UNIT_OVF_EN is defined.
interface full_adder_unit_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             in_valid;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             out_valid;
`ifdef FULL_ADDER_UNIT_OVF_EN
  logic             ovf;
`endif

  modport master (
    output a, b, ci, in_valid,
    input  s, co, out_valid
`ifdef FULL_ADDER_UNIT_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  a, b, ci, in_valid,
    output s, co, out_valid
`ifdef FULL_ADDER_UNIT_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/full_adder_unit.sv
// Ripple-carry adder {co, s} = a + b + ci, optionally registered with a valid strobe.
// Optional signed-overflow output enabled by macro FULL_ADDER_UNIT_OVF_EN.
module full_adder_unit #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input logic           clk,
  input logic           rst,
  full_adder_unit_if.slave bus
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  logic             co_next;
`ifdef FULL_ADDER_UNIT_OVF_EN
  logic             ovf_next;
`endif

  // Chain of 1-bit full-adder cells; c[0] is the carry-in.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = bus.ci;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i]   = bus.a[i] ^ bus.b[i] ^ c[i];
      c[i + 1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & c[i]) | (bus.b[i] & c[i]);
    end
  end

  assign co_next = c[WIDTH];
`ifdef FULL_ADDER_UNIT_OVF_EN
  assign ovf_next = c[WIDTH] ^ c[WIDTH-1];
`endif

  if (REG_OUT) begin : g_reg
    // Result registers load only on qualified cycles, so unqualified inputs never reach them.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bus.s         <= '0;
        bus.co        <= 1'b0;
        bus.out_valid <= 1'b0;
`ifdef FULL_ADDER_UNIT_OVF_EN
        bus.ovf       <= 1'b0;
`endif
      end else begin
        bus.out_valid <= bus.in_valid;
        if (bus.in_valid) begin
          bus.s  <= sum;
          bus.co <= co_next;
`ifdef FULL_ADDER_UNIT_OVF_EN
          bus.ovf <= ovf_next;
`endif
        end
      end
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
      bus.s         = sum;
      bus.co        = co_next;
      bus.out_valid = bus.in_valid;
`ifdef FULL_ADDER_UNIT_OVF_EN
      bus.ovf       = ovf_next;
`endif
    end
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// Directed self-checking bench for full_adder_unit (1-bit and 8-bit registered, 8-bit combinational).
module tb_full_adder_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  full_adder_unit_if #(.WIDTH(1)) bus1 ();
  full_adder_unit_if #(.WIDTH(8)) bus8 ();
  full_adder_unit_if #(.WIDTH(8)) busc ();

  full_adder_unit #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  full_adder_unit #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  full_adder_unit #(.WIDTH(8), .REG_OUT(1'b0)) dutc (.clk(clk), .rst(rst), .bus(busc.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives the registered and combinational 8-bit instances with the same operands.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic v);
    bus8.a = a; bus8.b = b; bus8.ci = ci; bus8.in_valid = v;
    busc.a = a; busc.b = b; busc.ci = ci; busc.in_valid = v;
  endtask

  logic [1:0] tab1 [8];
  logic [2:0] v3;

  initial begin
    checks = 0;
    errors = 0;
    tab1[0] = 2'b00; tab1[1] = 2'b01; tab1[2] = 2'b01; tab1[3] = 2'b10;
    tab1[4] = 2'b01; tab1[5] = 2'b10; tab1[6] = 2'b10; tab1[7] = 2'b11;

    rst = 1'b0;
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.ci = 1'b0; bus1.in_valid = 1'b0;
    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("rst_s8", bus8.s, 64'h0);
    check("rst_co8", bus8.co, 64'h0);
    check("rst_ov8", bus8.out_valid, 64'h0);
    check("rst_s1", {bus1.co, bus1.s}, 64'h0);
    check("rst_ov1", bus1.out_valid, 64'h0);
`ifdef FULL_ADDER_UNIT_OVF_EN
    check("rst_ovf8", bus8.ovf, 64'h0);
`endif
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;

    // 1-bit truth table
    for (int i = 0; i < 8; i++) begin
      v3 = i[2:0];
      bus1.a = v3[2]; bus1.b = v3[1]; bus1.ci = v3[0]; bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("w1_sum_%0d", i), {bus1.co, bus1.s}, {62'h0, tab1[i]});
      check($sformatf("w1_ov_%0d", i), bus1.out_valid, 64'h1);
    end
    bus1.in_valid = 1'b0;

    // all zeros
    drive8(8'h00, 8'h00, 1'b0, 1'b1);
    #1 check("c_zero", {busc.co, busc.s}, 64'h000);
    @(posedge clk); #1;
    check("zero", {bus8.co, bus8.s}, 64'h000);

    drive8(8'hFF, 8'h01, 1'b0, 1'b1);
    #1;
    check("c_ff01", {busc.co, busc.s}, 64'h100);
    check("c_ff01_ov", busc.out_valid, 64'h1);
    @(posedge clk); #1;
    check("ff01_s", bus8.s, 64'h00);
    check("ff01_co", bus8.co, 64'h1);
    check("ff01_ov", bus8.out_valid, 64'h1);

    drive8(8'hFF, 8'hFF, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("ffff1", {bus8.co, bus8.s}, 64'h1FF);

    drive8(8'h03, 8'h04, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("s34_s", {bus8.co, bus8.s}, 64'h008);
    check("s34_ov", bus8.out_valid, 64'h1);

    // unqualified X inputs must not disturb the held result
    drive8('x, 'x, 1'bx, 1'b0);
    #1 check("c_idle_ov", busc.out_valid, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold_s_%0d", i), {bus8.co, bus8.s}, 64'h008);
      check($sformatf("hold_ov_%0d", i), bus8.out_valid, 64'h0);
    end

    // asynchronous reset mid-period while a valid result is showing
    drive8(8'h03, 8'h04, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("pre_rst_ov", bus8.out_valid, 64'h1);
    check("pre_rst_s", bus8.s, 64'h08);
    #2 rst = 1'b1;
    #1;
    check("arst_s", bus8.s, 64'h00);
    check("arst_co", bus8.co, 64'h0);
    check("arst_ov", bus8.out_valid, 64'h0);
    @(posedge clk); #1;
    check("rst_held_ov", bus8.out_valid, 64'h0);
    check("rst_held_s", bus8.s, 64'h00);
    #2 rst = 1'b0;
    drive8(8'h10, 8'h20, 1'b0, 1'b1);
    #1 check("rel_pre_s", bus8.s, 64'h00);
    @(posedge clk); #1;
    check("rel_s", {bus8.co, bus8.s}, 64'h030);
    check("rel_ov", bus8.out_valid, 64'h1);

`ifdef FULL_ADDER_UNIT_OVF_EN
    drive8(8'h7F, 8'h01, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("ovf1", bus8.ovf, 64'h1);
    check("ovf1_s", {bus8.co, bus8.s}, 64'h080);
    drive8(8'h80, 8'h80, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("ovf2", bus8.ovf, 64'h1);
    check("ovf2_s", {bus8.co, bus8.s}, 64'h100);
    drive8(8'h01, 8'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("ovf_hold", bus8.ovf, 64'h1);
    drive8(8'h01, 8'h01, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("ovf_clr", bus8.ovf, 64'h0);
`endif

    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
